// File: rtl/wra_layer_sched.sv
// wra_layer_sched: layer sequencer for the Winograd accelerator controller.
// Holds a host-written table of per-layer tiling descriptors and walks it:
// for each layer the descriptor fields are registered onto the controller's
// configuration outputs, a one-cycle start pulse is issued, and the sequencer
// waits for Layer_Finish (guarded by a watchdog) before moving on.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   desc_we/addr/wdata descriptor table write port (ignored while busy)
//   go, num_layers     start request and layer count (sampled in IDLE)
//   abort              synchronous abort back to IDLE
//   Layer_Finish       end-of-layer pulse from the controller
//   inputbstart_op     single-cycle layer start pulse
//   *_op               registered descriptor fields for the current layer
//   busy, done         status: not idle / all layers finished pulse
//   cur_layer          index of the layer being fetched or run
//   err                sticky error (invalid descriptor or watchdog timeout)
module wra_layer_sched #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TO_W       = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_we,
  input  logic [DEPTH_LOG2-1:0] desc_addr,
  input  logic [31:0]           desc_wdata,
  input  logic                  go,
  input  logic [DEPTH_LOG2:0]   num_layers,
  input  logic                  abort,
  input  logic                  Layer_Finish,
  output logic                  inputbstart_op,
  output logic [8:0]            numslideH_op,
  output logic [4:0]            numswitchH_op,
  output logic [4:0]            numslideV_op,
  output logic [4:0]            NInch_D_PInch_op,
  output logic [4:0]            NOuch_D_POuch_op,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] cur_layer,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_t;

  // Watchdog value one step short of all-ones: seeing it in RUN means the
  // counter reaches all-ones on this edge, so the timeout is taken now.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t              state, state_nx;
  logic [31:0]         mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0]         rd_data;
  logic [DEPTH_LOG2:0] nl_q;
  logic [TO_W-1:0]     wd;
  logic                last_layer;
  logic                unused_rsvd;

  assign unused_rsvd = ^rd_data[30:29];
  assign last_layer  = ({1'b0, cur_layer} == (nl_q - 1'b1));

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign inputbstart_op = (state == S_START);

  // Descriptor table: written only while idle, read one cycle after FETCH.
  always_ff @(posedge clk) begin
    if (desc_we && state == S_IDLE) mem[desc_addr] <= desc_wdata;
    if (state == S_FETCH) rd_data <= mem[cur_layer];
  end

  always_comb begin
    state_nx = state;
    if (state != S_IDLE && abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (go) state_nx = (num_layers == '0) ? S_DONE : S_FETCH;
        S_FETCH: state_nx = S_LOAD;
        S_LOAD:  state_nx = rd_data[31] ? S_START : S_ERR;
        S_START: state_nx = S_RUN;
        S_RUN: begin
          if (Layer_Finish)     state_nx = S_NEXT;
          else if (wd == WD_LAST) state_nx = S_ERR;
        end
        S_NEXT:  state_nx = last_layer ? S_DONE : S_FETCH;
        S_DONE:  state_nx = S_IDLE;
        S_ERR:   state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      nl_q             <= '0;
      cur_layer        <= '0;
      err              <= 1'b0;
      wd               <= '0;
      numslideH_op     <= '0;
      numswitchH_op    <= '0;
      numslideV_op     <= '0;
      NInch_D_PInch_op <= '0;
      NOuch_D_POuch_op <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && go) begin
        err <= 1'b0;
        if (num_layers != '0) begin
          nl_q      <= num_layers;
          cur_layer <= '0;
        end
      end
      if (state_nx == S_ERR) err <= 1'b1;
      // Fields move only on a successful LOAD, so an abort or invalid
      // descriptor leaves the controller's configuration untouched.
      if (state == S_LOAD && state_nx == S_START) begin
        numslideH_op     <= rd_data[8:0];
        numswitchH_op    <= rd_data[13:9];
        numslideV_op     <= rd_data[18:14];
        NInch_D_PInch_op <= rd_data[23:19];
        NOuch_D_POuch_op <= rd_data[28:24];
      end
      if (state == S_START)    wd <= '0;
      else if (state == S_RUN) wd <= wd + 1'b1;
      if (state == S_NEXT && state_nx == S_FETCH) cur_layer <= cur_layer + 1'b1;
    end
  end

endmodule
